a8_bus_master: RTL
==================

# a8_bus_master

Synthesizable Atari 8-bit system-bus initiator, clocked from `sysclk`, that generates PHI2 and runs 6502-style read/write cycles with the standard A8 cycle shape. Address is valid about 177 ns into a 558 ns cycle, write data at about 422 ns, and read data is sampled at about 486 ns. It is the CPU-side counterpart of the `xe_host` cartridge-port responder. It drives `xe_host` in system-level simulation and on the bench-top replay rig, taking transactions from a simple valid/ready request port.

## Interface
Parameters (all counts in `sysclk` cycles):
- `CYCLE`, 56: bus cycle length; must be even and ≥ 8.
- `ADDR_DLY`, 18: count at which address and `rw_n` change.
- `WDATA_DLY`, 42: count at which write data is driven.
- `RSAMPLE`, 49: count at which read data is sampled.
- Required ordering: 0 < `ADDR_DLY` < `CYCLE`/2 ≤ `WDATA_DLY` < `RSAMPLE` < `CYCLE`-1.

Ports:
- `sysclk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: transaction request present.
- `req_ready` out 1: request accepted this clock.
- `req_rd` in 1: 1 = read, 0 = write.
- `req_addr` in 16: bus address.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-clock pulse carrying read data.
- `rsp_rdata` out 8: read data.
- `a8_clk` out 1: generated PHI2.
- `a8_a` out 16: address bus.
- `a8_a_oe` out 1: address/`rw_n` output enable.
- `a8_rw_n` out 1: 1 = read, 0 = write.
- `a8_d_out` out 8: data bus drive value.
- `a8_d_oe` out 1: data bus output enable.
- `a8_d_in` in 8: data bus input.
- `a8_halt_n` in 1: ANTIC halt; low steals the cycle.

## Operation
- Free-running cycle counter `cnt` runs 0..`CYCLE`-1 and wraps. `a8_clk` is 0 for `cnt` < `CYCLE`/2 and 1 otherwise, so each cycle starts with PHI2 low.
- At `cnt`==0, `a8_halt_n` is sampled:
  - Low: the cycle is HALTED. `req_ready`=0, `a8_a_oe` is 0 from `ADDR_DLY`, `a8_d_oe`=0, `a8_rw_n`=1. PHI2 keeps running.
  - High: `req_ready`=1 combinationally at `cnt`==0 only.
- Acceptance:
  - If `req_valid`, the request is accepted: addr/rd/wdata are latched and the cycle is a BUS cycle.
  - If not, the cycle is IDLE: a read of the last address, with no response issued.
- Per-cycle state machine: IDLE / READ / WRITE / HALTED, chosen at `cnt`==0 and held to `cnt`==`CYCLE`-1.
- At `cnt`==`ADDR_DLY`: `a8_a` and `a8_rw_n` update from the latched request, and `a8_a_oe`=1 unless HALTED.
- WRITE:
  - At `WDATA_DLY`, `a8_d_out`=wdata and `a8_d_oe`=1.
  - `a8_d_oe` clears on the wrap to `cnt`==0.
  - `a8_rw_n` stays 0 until the next `ADDR_DLY`.
- READ: `a8_d_in` is captured at `cnt`==`RSAMPLE`. `rsp_valid`=1 and `rsp_rdata`=captured value on the following clock, for exactly one clock.
- No response is issued for WRITE, IDLE or HALTED cycles.
- At most one request is accepted per bus cycle, and no queueing is done. The requester holds `req_valid` until `req_ready`.

## Timing
- Reset values: `cnt`=0, `a8_clk`=0, `a8_a`=0, `a8_a_oe`=0, `a8_rw_n`=1, `a8_d_out`=0, `a8_d_oe`=0, `rsp_valid`=0, `rsp_rdata`=0, `req_ready`=0 (gated by `rst`).
- First post-reset cycle starts at the first clock with `rst` low, with `cnt`=0.
- Request-to-address latency is `ADDR_DLY` clocks. Request-to-`rsp_valid` latency is `RSAMPLE`+1 clocks (50 at defaults).
- Back-to-back requests issue every `CYCLE` clocks. Address is driven continuously, changing only at `ADDR_DLY`.
- Reset mid-cycle: on the next clock, all outputs return to their reset values, the in-flight transaction is dropped with no `rsp_valid`, and the bus is released.
- `req_valid` dropping while `req_ready`=0 has no effect.
- `a8_halt_n` changing mid-cycle is ignored until the next `cnt`==0.

## Test plan
- Reset release:
  - `a8_clk` period is 56 clocks, low for counts 0–27.
  - All outputs hold reset values through `cnt`=17.
  - `a8_a_oe` rises at `cnt`=18.
- Write 0xD604←0x05:
  - Accepted at `cnt` 0.
  - `a8_a`=D604 and `a8_rw_n`=0 at `cnt` 18.
  - `a8_d_out`=05 and `a8_d_oe`=1 for counts 42–55.
  - No `rsp_valid`.
- Read 0xD604 with `a8_d_in`=0x5A from `cnt` 45: `rsp_valid` pulses at `cnt` 50 with `rsp_rdata`=5A, and `a8_d_oe` stays 0.
- Three requests held valid (write D605←10, write D601←01, read 0607): accepted at successive cycle starts 56 clocks apart, with addresses appearing at 18, 74 and 130.
- `a8_halt_n`=0 at a cycle start with a request pending:
  - `req_ready`=0 and `a8_a_oe`=0 that cycle.
  - The request is accepted at the next `cnt` 0.
- `rst` pulsed at `cnt` 45 of a write: `a8_d_oe`=0 and `a8_rw_n`=1 the next clock, no response, and the counter restarts at 0.

Source files
------------

// File: rtl/a8_bus_master.sv
// a8_bus_master: Atari 8-bit system-bus initiator. It derives PHI2 from sysclk
// and runs one 6502-style bus cycle (IDLE / READ / WRITE / HALTED) every CYCLE
// clocks. A simple valid/ready port feeds it one request per cycle.
module a8_bus_master #(
    parameter int unsigned CYCLE     = 56,  // bus cycle length, even, >= 8
    parameter int unsigned ADDR_DLY  = 18,  // count where a8_a / a8_rw_n change
    parameter int unsigned WDATA_DLY = 42,  // count where write data is driven
    parameter int unsigned RSAMPLE   = 49   // count where read data is sampled
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        a8_clk,
    output logic [15:0] a8_a,
    output logic        a8_a_oe,
    output logic        a8_rw_n,
    output logic [7:0]  a8_d_out,
    output logic        a8_d_oe,
    input  logic [7:0]  a8_d_in,
    input  logic        a8_halt_n
);

    localparam int unsigned CW = $clog2(CYCLE);

    // Registered outputs become visible one clock after the count they are
    // loaded on, so each event is loaded at its nominal count minus one.
    localparam logic [CW-1:0] CNT_LAST    = CW'(CYCLE - 1);
    localparam logic [CW-1:0] CNT_HALF    = CW'(CYCLE / 2);
    localparam logic [CW-1:0] CNT_ADDR    = CW'(ADDR_DLY - 1);
    localparam logic [CW-1:0] CNT_WDATA   = CW'(WDATA_DLY - 1);
    localparam logic [CW-1:0] CNT_RSAMPLE = CW'(RSAMPLE);

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_READ   = 2'd1,
        M_WRITE  = 2'd2,
        M_HALTED = 2'd3
    } mode_e;

    logic [CW-1:0] cnt_q, cnt_d;
    mode_e         mode_q, mode_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          cyc_start;

    logic          a8_clk_q;
    logic [15:0]   a8_a_q;
    logic          a8_a_oe_q;
    logic          a8_rw_n_q;
    logic [7:0]    a8_d_out_q;
    logic          a8_d_oe_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_rdata_q;

    assign cyc_start = (cnt_q == '0);

    // Ready is offered only in the first clock of a non-halted cycle.
    assign req_ready = !rst && cyc_start && a8_halt_n;

    // Counter wrap and cycle-type / request latch selection at cycle start.
    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (cyc_start) begin
            if (!a8_halt_n) begin
                mode_d = M_HALTED;
            end else if (req_valid) begin
                mode_d  = req_rd ? M_READ : M_WRITE;
                addr_d  = req_addr;
                wdata_d = req_wdata;
            end else begin
                mode_d = M_IDLE;
            end
        end
    end

    // Cycle state machine and all registered bus/response outputs.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt_q       <= '0;
            mode_q      <= M_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            a8_clk_q    <= 1'b0;
            a8_a_q      <= '0;
            a8_a_oe_q   <= 1'b0;
            a8_rw_n_q   <= 1'b1;
            a8_d_out_q  <= '0;
            a8_d_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            a8_clk_q    <= (cnt_d >= CNT_HALF);
            rsp_valid_q <= 1'b0;

            // Address phase: IDLE and HALTED cycles present the last address
            // as a read; HALTED additionally releases the address bus.
            if (cnt_q == CNT_ADDR) begin
                a8_a_q    <= addr_d;
                a8_rw_n_q <= (mode_d != M_WRITE);
                a8_a_oe_q <= (mode_d != M_HALTED);
            end

            // Write data is driven from WDATA_DLY to the end of the cycle.
            if ((cnt_q == CNT_WDATA) && (mode_d == M_WRITE)) begin
                a8_d_out_q <= wdata_d;
                a8_d_oe_q  <= 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                a8_d_oe_q <= 1'b0;
            end

            // Read data is captured at RSAMPLE and returned the next clock.
            if ((cnt_q == CNT_RSAMPLE) && (mode_d == M_READ)) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= a8_d_in;
            end
        end
    end

    assign a8_clk    = a8_clk_q;
    assign a8_a      = a8_a_q;
    assign a8_a_oe   = a8_a_oe_q;
    assign a8_rw_n   = a8_rw_n_q;
    assign a8_d_out  = a8_d_out_q;
    assign a8_d_oe   = a8_d_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
